// File: rtl/mem_byte_sequencer.sv
// Serialises one RISC-V load/store request into little-endian byte accesses
// on an 8-bit synchronous SRAM port, with load sign/zero extension.
module mem_byte_sequencer #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           address,
    input  logic [2:0]            mode,
    input  logic                  write_enable,
    input  logic [31:0]           write_data,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           read_data,
    output logic                  active,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [2:0]            mode;
        logic                  we;
        logic [31:0]           wdata;
    } req_t;

    state_t          state, state_nxt;
    req_t            req;
    logic [1:0]      idx, idx_nxt, last_idx;
    logic [1:0]      mem_lane, cap_lane;
    logic            cap_vld, err_q, reject;
    logic [3:0][7:0] lanes, lanes_full;
    logic [31:0]     ext;

    assign last_idx = req.mode[1] ? 2'd3 : (req.mode[0] ? 2'd1 : 2'd0);
    assign idx_nxt  = idx + 2'd1;

    always_comb begin
        reject = 1'b0;
        if (mode == 3'b011 || mode == 3'b110 || mode == 3'b111) reject = 1'b1;
        if (write_enable && mode[2])                            reject = 1'b1;
        if (mode[1:0] == 2'b01 && address[0])                   reject = 1'b1;
        if (mode == 3'b010 && address[1:0] != 2'b00)            reject = 1'b1;
        if ((address >> ADDR_WIDTH) != 32'd0)                   reject = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = reject ? DONE : ISSUE;
            ISSUE: if (idx == last_idx) state_nxt = req.we ? DONE : DRAIN;
            DRAIN: state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        done   = (state == DONE);
        error  = (state == DONE) && err_q;
        active = (state != IDLE);
    end

    // The byte still in flight on mem_rdata during DRAIN is folded in here
    always_comb begin
        lanes_full = lanes;
        if (cap_vld) lanes_full[cap_lane] = mem_rdata;
        case (req.mode)
            3'b000:  ext = {{24{lanes_full[0][7]}}, lanes_full[0]};
            3'b001:  ext = {{16{lanes_full[1][7]}}, lanes_full[1], lanes_full[0]};
            3'b100:  ext = {24'd0, lanes_full[0]};
            3'b101:  ext = {16'd0, lanes_full[1], lanes_full[0]};
            default: ext = lanes_full;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req       <= '0;
            idx       <= 2'd0;
            err_q     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
            mem_lane  <= 2'd0;
            cap_vld   <= 1'b0;
            cap_lane  <= 2'd0;
            lanes     <= '0;
            read_data <= 32'd0;
        end else begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            cap_vld  <= mem_en & ~mem_we;
            cap_lane <= mem_lane;
            if (cap_vld) lanes[cap_lane] <= mem_rdata;
            case (state)
                IDLE: begin
                    idx <= 2'd0;
                    if (start) begin
                        req   <= '{addr: address[ADDR_WIDTH-1:0], mode: mode,
                                   we: write_enable, wdata: write_data};
                        err_q <= reject;
                        if (!reject) begin
                            mem_en    <= 1'b1;
                            mem_we    <= write_enable;
                            mem_addr  <= address[ADDR_WIDTH-1:0];
                            mem_wdata <= write_data[7:0];
                            mem_lane  <= 2'd0;
                        end
                    end
                end
                ISSUE: begin
                    if (idx != last_idx) begin
                        idx       <= idx_nxt;
                        mem_en    <= 1'b1;
                        mem_we    <= req.we;
                        mem_addr  <= req.addr + ADDR_WIDTH'(idx_nxt);
                        mem_wdata <= req.wdata[{idx_nxt, 3'b000} +: 8];
                        mem_lane  <= idx_nxt;
                    end else begin
                        idx <= 2'd0;
                    end
                end
                DRAIN: read_data <= ext;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Scoreboarded bench for mem_byte_sequencer with a behavioural 8-bit SRAM.
module tb_mem_byte_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] address = '0;
    logic [2:0]  mode = '0;
    logic        write_enable = 1'b0;
    logic [31:0] write_data = '0;
    logic        done, error, active, mem_en, mem_we;
    logic [31:0] read_data;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    typedef struct packed {
        logic        err;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb[$];
    logic [23:0] wlog[$];
    logic [7:0]  sram [0:65535];
    int          acc_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd = '0;

    always #5 clk = ~clk;

    mem_byte_sequencer #(.ADDR_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .address(address), .mode(mode),
        .write_enable(write_enable), .write_data(write_data), .done(done),
        .error(error), .read_data(read_data), .active(active), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Synchronous SRAM: read data appears the cycle after the issue
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            acc_cnt++;
            if (mem_we === 1'b1) begin
                sram[mem_addr] <= mem_wdata;
                wlog.push_back({mem_addr, mem_wdata});
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("error_flag", {31'd0, error}, {31'd0, e.err});
                chk("read_data", read_data, e.rd);
            end
        end
    end

    task automatic do_req(input logic w, input logic [2:0] m, input logic [31:0] a,
                          input logic [31:0] wd, input int exp_lat, input logic exp_err,
                          input logic [31:0] exp_rd);
        int   lat, acc0, n;
        logic act_ok, en_ok;
        exp_t e;
        e.err = exp_err;
        e.rd  = (!w && !exp_err) ? exp_rd : last_rd;
        last_rd = e.rd;
        sb.push_back(e);
        n = m[1] ? 4 : (m[0] ? 2 : 1);
        acc0 = acc_cnt;
        start = 1'b1; write_enable = w; mode = m; address = a; write_data = wd;
        @(posedge clk); #1;
        // Inputs move after the sampling edge; the latched request must not
        start = 1'b0; address = a ^ 32'h4; write_data = ~wd; mode = m ^ 3'b001;
        write_enable = ~w;
        lat = 0; act_ok = 1'b1; en_ok = 1'b1;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (active !== 1'b1) act_ok = 1'b0;
            if (exp_err && mem_en !== 1'b0) en_ok = 1'b0;
            if (done === 1'b1) lat = k;
        end
        chk("latency", lat, exp_lat);
        chk("active_busy", {31'd0, act_ok}, 32'd1);
        if (exp_err) chk("reject_mem_en", {31'd0, en_ok}, 32'd1);
        @(negedge clk);
        chk("active_after", {31'd0, active}, 32'd0);
        chk("access_count", acc_cnt - acc0, exp_err ? 0 : n);
    endtask

    initial begin
        int   dcnt, acc0;
        logic [23:0] wexp [4];
        wexp[0] = 24'h0010EF; wexp[1] = 24'h0011BE;
        wexp[2] = 24'h0012AD; wexp[3] = 24'h0013DE;

        #12;
        chk("rst_done",  {31'd0, done},   32'd0);
        chk("rst_error", {31'd0, error},  32'd0);
        chk("rst_active",{31'd0, active}, 32'd0);
        chk("rst_mem_en",{31'd0, mem_en}, 32'd0);
        chk("rst_mem_we",{31'd0, mem_we}, 32'd0);
        chk("rst_addr",  {16'd0, mem_addr}, 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);

        // Store word, then read it back
        wlog.delete();
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5, 1'b0, 32'h0);
        chk("sw_writes", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) chk($sformatf("sw_byte%0d", i), {8'd0, wlog[i]}, {8'd0, wexp[i]});
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 6, 1'b0, 32'hDEADBEEF);

        // Reset in cycle 2 of an LW: drop everything, no done
        start = 1'b1; write_enable = 1'b0; mode = 3'b010; address = 32'h10;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0; #1;
        chk("mid_rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("mid_rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("mid_rst_active", {31'd0, active}, 32'd0);
        chk("mid_rst_done",   {31'd0, done},   32'd0);
        chk("mid_rst_rdata",  read_data, 32'd0);
        chk("mid_rst_wdata",  {24'd0, mem_wdata}, 32'd0);
        last_rd = 32'd0;
        @(negedge clk); rst = 1'b1;
        repeat (8) @(negedge clk);

        // Sub-word stores and loads with extension
        do_req(1'b1, 3'b000, 32'h20, 32'h11223380, 2, 1'b0, 32'h0);
        do_req(1'b1, 3'b000, 32'h21, 32'h445566FF, 2, 1'b0, 32'h0);
        do_req(1'b0, 3'b000, 32'h20, 32'h0, 3, 1'b0, 32'hFFFFFF80);
        do_req(1'b0, 3'b100, 32'h20, 32'h0, 3, 1'b0, 32'h00000080);
        do_req(1'b0, 3'b001, 32'h20, 32'h0, 4, 1'b0, 32'hFFFFFF80);
        do_req(1'b0, 3'b101, 32'h20, 32'h0, 4, 1'b0, 32'h0000FF80);
        do_req(1'b1, 3'b001, 32'h22, 32'hAAAA1234, 3, 1'b0, 32'h0);
        do_req(1'b0, 3'b101, 32'h22, 32'h0, 4, 1'b0, 32'h00001234);
        do_req(1'b0, 3'b000, 32'h23, 32'h0, 3, 1'b0, 32'h00000012);

        // Rejections
        do_req(1'b0, 3'b010, 32'h12,       32'h0, 1, 1'b1, 32'h0);
        do_req(1'b1, 3'b001, 32'h11,       32'h5555, 1, 1'b1, 32'h0);
        do_req(1'b0, 3'b011, 32'h10,       32'h0, 1, 1'b1, 32'h0);
        do_req(1'b1, 3'b100, 32'h20,       32'h77, 1, 1'b1, 32'h0);
        do_req(1'b0, 3'b010, 32'h00010000, 32'h0, 1, 1'b1, 32'h0);

        // Start pulses in cycles 2 and 6 of an LW are ignored
        sb.push_back('{err: 1'b0, rd: 32'hDEADBEEF});
        last_rd = 32'hDEADBEEF;
        acc0 = acc_cnt; dcnt = 0;
        start = 1'b1; write_enable = 1'b0; mode = 3'b010; address = 32'h10;
        @(posedge clk); #1;
        start = 1'b0; write_enable = 1'b1; mode = 3'b000; address = 32'h30;
        write_data = 32'h5A;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dcnt++;
                chk("busy_done_cycle", k, 6);
            end
            start = (k == 2 || k == 6);
        end
        start = 1'b0;
        chk("busy_done_count", dcnt, 1);
        chk("busy_access_count", acc_cnt - acc0, 4);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
